// File: rtl/rrat_retire.sv
// Retirement RAT: records committed arch->phys mappings, returns displaced
// physical registers to the free list, and streams the table out on a flush.
module rrat_retire #(
  parameter int ARCH_REGS  = 32,
  parameter int ARCH_WIDTH = 5,
  parameter int PHYS_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commit_valid_i,
  input  logic [ARCH_WIDTH-1:0] commit_rd_i,
  input  logic [PHYS_WIDTH-1:0] commit_pd_i,
  output logic                  commit_ready_o,
  output logic                  free_valid_o,
  output logic [PHYS_WIDTH-1:0] free_pd_o,
  input  logic                  flush_req_i,
  output logic                  restore_valid_o,
  output logic [ARCH_WIDTH-1:0] restore_rd_o,
  output logic [PHYS_WIDTH-1:0] restore_pd_o,
  output logic                  restore_done_o
);

  typedef enum logic [1:0] {IDLE, RESTORE, DONE} state_e;

  localparam logic [ARCH_WIDTH-1:0] LastIdx = ARCH_WIDTH'(ARCH_REGS - 1);

  state_e                  state_q;
  logic [PHYS_WIDTH-1:0]   table_q [ARCH_REGS];
  logic [ARCH_WIDTH-1:0]   walk_q;
  logic [ARCH_WIDTH-1:0]   walk_d;
  logic                    free_valid_q;
  logic [PHYS_WIDTH-1:0]   free_pd_q;
  logic                    restore_valid_q;
  logic [ARCH_WIDTH-1:0]   restore_rd_q;
  logic [PHYS_WIDTH-1:0]   restore_pd_q;
  logic                    restore_done_q;
  logic                    commit_accept;
  logic                    commit_write;

  assign commit_ready_o = (state_q == IDLE);
  assign commit_accept  = commit_valid_i && commit_ready_o;
  assign commit_write   = commit_accept && (commit_rd_i != '0);
  assign walk_d         = walk_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        table_q[i] <= PHYS_WIDTH'(i);
      end
      state_q         <= IDLE;
      walk_q          <= '0;
      free_valid_q    <= 1'b0;
      free_pd_q       <= '0;
      restore_valid_q <= 1'b0;
      restore_rd_q    <= '0;
      restore_pd_q    <= '0;
      restore_done_q  <= 1'b0;
    end else begin
      free_valid_q <= commit_write;
      if (commit_write) begin
        free_pd_q            <= table_q[commit_rd_i];
        table_q[commit_rd_i] <= commit_pd_i;
      end

      // Beat 0 is emitted on the flush edge itself; arch reg 0 is never
      // written, so a same-cycle commit cannot make this beat stale.
      case (state_q)
        IDLE: begin
          if (flush_req_i) begin
            state_q         <= RESTORE;
            walk_q          <= '0;
            restore_valid_q <= 1'b1;
            restore_rd_q    <= '0;
            restore_pd_q    <= table_q[0];
          end
        end
        RESTORE: begin
          if (walk_q == LastIdx) begin
            state_q         <= DONE;
            walk_q          <= '0;
            restore_valid_q <= 1'b0;
            restore_done_q  <= 1'b1;
          end else begin
            walk_q       <= walk_d;
            restore_rd_q <= walk_d;
            restore_pd_q <= table_q[walk_d];
          end
        end
        DONE: begin
          restore_done_q <= 1'b0;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign free_valid_o    = free_valid_q;
  assign free_pd_o       = free_pd_q;
  assign restore_valid_o = restore_valid_q;
  assign restore_rd_o    = restore_rd_q;
  assign restore_pd_o    = restore_pd_q;
  assign restore_done_o  = restore_done_q;

endmodule

// File: tb/tb_rrat_retire.sv
// Bench for rrat_retire: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a flush-sequence model.
module tb_rrat_retire;

  logic       clk;
  logic       rst;
  logic       commitValid;
  logic [4:0] commitRd;
  logic [5:0] commitPd;
  logic       commitReady;
  logic       freeValid;
  logic [5:0] freePd;
  logic       flushReq;
  logic       restoreValid;
  logic [4:0] restoreRd;
  logic [5:0] restorePd;
  logic       restoreDone;

  int checks;
  int failures;

  // Model: committed table plus position within a flush sequence
  // (0 = idle, 1..32 = beat index + 1, 33 = done pulse).
  logic [5:0] mdlTable [32];
  int         phase;
  logic       expFreeValid;
  logic [5:0] expFreePd;
  logic       modelReady;

  int capPd [32];
  int beats;
  bit doneSeen;

  rrat_retire #(
    .ARCH_REGS(32),
    .ARCH_WIDTH(5),
    .PHYS_WIDTH(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .commit_valid_i(commitValid),
    .commit_rd_i(commitRd),
    .commit_pd_i(commitPd),
    .commit_ready_o(commitReady),
    .free_valid_o(freeValid),
    .free_pd_o(freePd),
    .flush_req_i(flushReq),
    .restore_valid_o(restoreValid),
    .restore_rd_o(restoreRd),
    .restore_pd_o(restorePd),
    .restore_done_o(restoreDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit cv, input logic [4:0] rd, input logic [5:0] pd, input bit fl);
    commitValid = cv;
    commitRd    = rd;
    commitPd    = pd;
    flushReq    = fl;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mdlTable[i] <= 6'(i);
      phase        <= 0;
      expFreeValid <= 1'b0;
      expFreePd    <= '0;
    end else begin
      if (commitValid && phase == 0 && commitRd != 5'd0) begin
        expFreeValid       <= 1'b1;
        expFreePd          <= mdlTable[commitRd];
        mdlTable[commitRd] <= commitPd;
      end else begin
        expFreeValid <= 1'b0;
      end
      if (phase == 0)       phase <= flushReq ? 1 : 0;
      else if (phase == 33) phase <= 0;
      else                  phase <= phase + 1;
    end
    modelReady <= 1'b1;
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (modelReady === 1'b1) begin
      checkOutput("commit_ready", commitReady, (phase == 0));
      checkOutput("free_valid", freeValid, expFreeValid);
      if (expFreeValid) checkOutput("free_pd", freePd, expFreePd);
      checkOutput("restore_valid", restoreValid, (phase >= 1 && phase <= 32));
      checkOutput("restore_done", restoreDone, (phase == 33));
      if (phase >= 1 && phase <= 32) begin
        checkOutput("restore_rd", restoreRd, phase - 1);
        checkOutput("restore_pd", restorePd, mdlTable[phase-1]);
      end
    end
  end

  task automatic flushCapture(input bit cv, input logic [4:0] rd, input logic [5:0] pd,
                              input int expFree, input int injectBeat,
                              input logic [4:0] injRd, input logic [5:0] injPd);
    beats    = 0;
    doneSeen = 0;
    for (int i = 0; i < 32; i++) capPd[i] = -1;
    applyStimulus(cv, rd, pd, 1'b1);
    if (expFree >= 0) begin
      checkOutput("flush_commit_free_valid", freeValid, 1);
      checkOutput("flush_commit_free_pd", freePd, expFree);
    end
    for (int n = 1; n <= 40 && !doneSeen; n++) begin
      if (restoreValid) begin
        checkOutput("beat_cycle", restoreRd, n - 1);
        capPd[restoreRd] = int'(restorePd);
        beats++;
      end
      if (restoreDone) begin
        doneSeen = 1;
        checkOutput("done_cycle", n, 33);
        checkOutput("ready_during_done", commitReady, 0);
      end
      if (!doneSeen) begin
        if (restoreValid && int'(restoreRd) == injectBeat) begin
          applyStimulus(1'b1, injRd, injPd, 1'b0);
          checkOutput("ignored_commit_free", freeValid, 0);
        end else begin
          applyStimulus(1'b0, '0, '0, 1'b0);
        end
      end
    end
    checkOutput("restore_beats", beats, 32);
    checkOutput("restore_done_seen", doneSeen, 1);
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("ready_after_done", commitReady, 1);
  endtask

  initial begin
    bit reached;
    checks      = 0;
    failures    = 0;
    modelReady  = 1'b0;
    rst         = 1'b1;
    commitValid = 1'b0;
    commitRd    = '0;
    commitPd    = '0;
    flushReq    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_ready", commitReady, 1);
    checkOutput("reset_free_valid", freeValid, 0);
    checkOutput("reset_free_pd", freePd, 0);
    checkOutput("reset_restore_valid", restoreValid, 0);
    checkOutput("reset_restore_rd", restoreRd, 0);
    checkOutput("reset_restore_pd", restorePd, 0);
    checkOutput("reset_restore_done", restoreDone, 0);
    rst = 1'b0;

    $display("[TB] identity restore after reset");
    flushCapture(1'b0, '0, '0, -1, -1, '0, '0);
    for (int i = 0; i < 32; i++) checkOutput("identity_beat_pd", capPd[i], i);

    $display("[TB] repeated commit to rd 5");
    applyStimulus(1'b1, 5'd5, 6'd40, 1'b0);
    checkOutput("c5a_free_valid", freeValid, 1);
    checkOutput("c5a_free_pd", freePd, 5);
    applyStimulus(1'b1, 5'd5, 6'd41, 1'b0);
    checkOutput("c5b_free_valid", freeValid, 1);
    checkOutput("c5b_free_pd", freePd, 40);
    applyStimulus(1'b1, 5'd0, 6'd50, 1'b0);
    checkOutput("rd0_free_valid", freeValid, 0);
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("idle_free_valid", freeValid, 0);
    flushCapture(1'b0, '0, '0, -1, -1, '0, '0);
    checkOutput("beat5_pd", capPd[5], 41);
    checkOutput("beat0_pd", capPd[0], 0);

    $display("[TB] back-to-back commits");
    applyStimulus(1'b1, 5'd1, 6'd33, 1'b0);
    checkOutput("b2b1_free_pd", freePd, 1);
    applyStimulus(1'b1, 5'd2, 6'd34, 1'b0);
    checkOutput("b2b2_free_valid", freeValid, 1);
    checkOutput("b2b2_free_pd", freePd, 2);
    applyStimulus(1'b1, 5'd3, 6'd35, 1'b0);
    checkOutput("b2b3_free_valid", freeValid, 1);
    checkOutput("b2b3_free_pd", freePd, 3);

    $display("[TB] commit with flush, commit during restore");
    flushCapture(1'b1, 5'd7, 6'd45, 7, 3, 5'd8, 6'd46);
    checkOutput("beat7_pd", capPd[7], 45);
    checkOutput("beat8_pd", capPd[8], 8);
    checkOutput("beat1_pd", capPd[1], 33);

    $display("[TB] reset mid-restore");
    applyStimulus(1'b1, 5'd12, 6'd60, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1);
    reached = 0;
    for (int n = 0; n < 40 && !reached; n++) begin
      if (restoreValid && restoreRd == 5'd10) reached = 1;
      else applyStimulus(1'b0, '0, '0, 1'b0);
    end
    checkOutput("reached_beat10", reached, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_restore_valid", restoreValid, 0);
    checkOutput("midrst_ready", commitReady, 1);
    checkOutput("midrst_free_valid", freeValid, 0);
    flushCapture(1'b0, '0, '0, -1, -1, '0, '0);
    for (int i = 0; i < 32; i++) checkOutput("post_reset_identity_pd", capPd[i], i);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0);
        rst = 1'b0;
      end else begin
        applyStimulus(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)),
                      6'($urandom_range(0, 63)), ($urandom_range(0, 39) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
